piso_shift_reg: RTL and testbench



---
 rtl/piso_shift_reg.sv | 95 +++++++++
 tb/tb_piso_shift_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in, serial-out shift register.
// Accepts a word through a valid/ready load handshake and shifts it out one
// bit per enabled clock, MSB or LSB first as selected at load time. Pairs with
// the serial-in shift_reg receiver sharing en/dir.
//
// Ports:
//   clk        - clock, rising-edge active
//   rstn       - asynchronous active-low reset
//   din        - parallel word to transmit
//   load_valid - din is valid, request to load
//   load_ready - block can accept a word this cycle
//   dir        - shift order sampled at load (0 = MSB first, 1 = LSB first)
//   en         - shift enable; one bit consumed per enabled edge while q_valid
//   q          - current serial bit (0 when q_valid = 0)
//   q_valid    - q carries a word bit
//   last       - q is the final bit of the current word
module piso_shift_reg #(
    parameter int unsigned MSB = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [MSB-1:0] din,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic           dir,
    input  logic           en,
    output logic           q,
    output logic           q_valid,
    output logic           last
);

    localparam int unsigned CW = (MSB > 1) ? $clog2(MSB) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [MSB-1:0] sr, sr_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           dir_q, dir_nx;
    logic           load_fire;

    // Outputs decode straight from registered state; load_ready also sees en
    // so a new word can be taken on the final-bit edge with no idle gap.
    assign q_valid    = (state == SHIFT);
    assign last       = q_valid && (cnt == CW'(MSB - 1));
    assign load_ready = (state == IDLE) || (last && en);
    assign q          = q_valid ? (dir_q ? sr[0] : sr[MSB-1]) : 1'b0;
    assign load_fire  = load_valid && load_ready;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
            dir_q <= dir_nx;
        end
    end

    // Next-state: a load wins over the final shift of the previous word
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        dir_nx   = dir_q;

        if (load_fire) begin
            sr_nx    = din;
            dir_nx   = dir;
            cnt_nx   = '0;
            state_nx = SHIFT;
        end else if ((state == SHIFT) && en) begin
            if (dir_q) begin
                sr_nx = {1'b0, sr[MSB-1:1]};
            end else begin
                sr_nx = {sr[MSB-2:0], 1'b0};
            end
            if (last) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed testbench for piso_shift_reg with a loop-back receiver model.
module tb_piso_shift_reg;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] din = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         dir = 1'b0;
    logic         en = 1'b0;
    logic         q;
    logic         q_valid;
    logic         last;

    int checks = 0;
    int errors = 0;
    int vcnt;
    int lcnt;
    int cyc;

    logic [W-1:0] w;
    logic [W-1:0] w2;
    logic [W-1:0] rx = '0;
    logic         rxdir = 1'b0;

    piso_shift_reg #(.MSB(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dir        (dir),
        .en         (en),
        .q          (q),
        .q_valid    (q_valid),
        .last       (last)
    );

    always #5 clk = ~clk;

    // Receiver model: serial-in shift register sampling q on consumed edges
    always @(posedge clk) begin
        if (en && q_valid) begin
            rx <= rxdir ? {q, rx[W-1:1]} : {rx[W-2:0], q};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [W-1:0] word, input logic d, input int i);
        return d ? word[i] : word[W-1-i];
    endfunction

    // Check one serial bit, then advance to the next falling edge
    task automatic step(input string tag, input logic eq, input logic el);
        chk1({tag, " q"}, q, eq);
        chk1({tag, " q_valid"}, q_valid, 1'b1);
        chk1({tag, " last"}, last, el);
        if (last) lcnt++;
        if (q_valid) vcnt++;
        @(negedge clk);
    endtask

    // Present a word for one accepting edge; dir/din are scrambled afterwards
    task automatic load(input logic [W-1:0] word, input logic d);
        din        = word;
        dir        = d;
        load_valid = 1'b1;
        chk1("load ready", load_ready, 1'b1);
        @(negedge clk);
        load_valid = 1'b0;
        dir        = ~d;
        din        = ~word;
    endtask

    initial begin
        w  = 16'hA5C3;
        w2 = 16'h00FF;

        // Reset state
        #12;
        chk1("rst q", q, 1'b0);
        chk1("rst q_valid", q_valid, 1'b0);
        chk1("rst last", last, 1'b0);
        chk1("rst load_ready", load_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        en   = 1'b1;
        @(negedge clk);
        chk1("idle q_valid", q_valid, 1'b0);
        chk1("idle load_ready", load_ready, 1'b1);

        // MSB first
        rxdir = 1'b0;
        vcnt = 0; lcnt = 0;
        load(w, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) chk1("msb last ready", load_ready, 1'b1);
            step("msb", exp_bit(w, 1'b0, i), i == W - 1);
        end
        chk1("msb done q_valid", q_valid, 1'b0);
        chk("msb rx", 32'(rx), 32'(w));
        chk("msb lasts", 32'(lcnt), 32'd1);

        // LSB first
        rxdir = 1'b1;
        load(w, 1'b1);
        for (int i = 0; i < W; i++) begin
            step("lsb", exp_bit(w, 1'b1, i), i == W - 1);
        end
        chk1("lsb done q_valid", q_valid, 1'b0);
        chk("lsb rx", 32'(rx), 32'(w));

        // Stall: en low for three cycles while bit 7 is on q
        rxdir = 1'b0;
        cyc = 0;
        load(w, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (i == 6) begin
                en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk1("stall q", q, exp_bit(w, 1'b0, 6));
                    chk1("stall q_valid", q_valid, 1'b1);
                    chk1("stall last", last, 1'b0);
                    cyc++;
                    @(negedge clk);
                end
                en = 1'b1;
            end
            step("stall", exp_bit(w, 1'b0, i), i == W - 1);
            cyc++;
        end
        chk1("stall done q_valid", q_valid, 1'b0);
        chk("stall cycles", 32'(cyc), 32'd19);
        chk("stall rx", 32'(rx), 32'(w));

        // Back-to-back: second word taken on the last-bit edge
        vcnt = 0; lcnt = 0;
        load(w, 1'b0);
        for (int i = 0; i < 2 * W; i++) begin
            if (i == W - 2) begin
                din        = w2;
                dir        = 1'b0;
                load_valid = 1'b1;
                chk1("b2b busy ready", load_ready, 1'b0);
            end
            if (i == W - 1) chk1("b2b last ready", load_ready, 1'b1);
            if (i == W) begin
                load_valid = 1'b0;
                dir        = 1'b1;
            end
            step("b2b", (i < W) ? exp_bit(w, 1'b0, i) : exp_bit(w2, 1'b0, i - W),
                 (i == W - 1) || (i == 2 * W - 1));
        end
        chk1("b2b done q_valid", q_valid, 1'b0);
        chk("b2b valid cycles", 32'(vcnt), 32'd32);
        chk("b2b lasts", 32'(lcnt), 32'd2);
        chk("b2b rx", 32'(rx), 32'(w2));

        // Busy reject: load attempt during bit 4 is ignored
        load(w, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (i == 3) begin
                din        = 16'hFFFF;
                load_valid = 1'b1;
                chk1("reject ready", load_ready, 1'b0);
            end
            if (i == 4) load_valid = 1'b0;
            step("reject", exp_bit(w, 1'b0, i), i == W - 1);
        end
        chk1("reject done q_valid", q_valid, 1'b0);
        chk("reject rx", 32'(rx), 32'(w));

        // Asynchronous reset mid-word, between clock edges
        load(w, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("prerst", exp_bit(w, 1'b0, i), 1'b0);
        end
        chk1("prerst q", q, 1'b1);
        chk1("prerst load_ready", load_ready, 1'b0);
        rstn = 1'b0;
        #1;
        chk1("arst q", q, 1'b0);
        chk1("arst q_valid", q_valid, 1'b0);
        chk1("arst last", last, 1'b0);
        chk1("arst load_ready", load_ready, 1'b1);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk1("postrst q_valid", q_valid, 1'b0);
        chk1("postrst q", q, 1'b0);
        chk1("postrst load_ready", load_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
